// File: rtl/cx_types_pkg.sv
// cx_types_pkg: shared fixed-point types plus requantizer constants and a reference
// convergent-round/saturate function.
package cx_types_pkg;
    localparam int WIDTH      = 16;
    localparam int FRAC_WIDTH = 15;
    localparam int REQ_DROP   = FRAC_WIDTH;
    localparam int REQ_LAT    = 2;

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic signed [2*WIDTH:0] mac_t;
    typedef sample_t requant_t;

    typedef struct packed {
        logic     sat;
        requant_t d;
    } req_res_t;

    // Arithmetic reference: floor-divide, then bump by the remainder rule.
    function automatic req_res_t conv_round_sat(input mac_t x);
        longint v, q, rem, half, lim;
        req_res_t r;
        v    = longint'(x);
        half = longint'(1) <<< (REQ_DROP - 1);
        lim  = longint'(1) <<< (WIDTH - 1);
        q    = v >>> REQ_DROP;
        rem  = v - (q <<< REQ_DROP);
        if (rem > half || (rem == half && (q & 1) != 0))
            q = q + 1;
        r.sat = (q > lim - 1) || (q < -lim);
        r.d   = (q > lim - 1) ? requant_t'(lim - 1) : (q < -lim) ? requant_t'(-lim) : requant_t'(q);
        return r;
    endfunction
endpackage

// File: rtl/alpaca_axis_pipe_reg.sv
// alpaca_axis_pipe_reg: one valid/data register slice; loads whenever it is empty
// or the downstream consumer is taking its contents.
module alpaca_axis_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         en_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign en_o    = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_o) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end
endmodule

// File: rtl/alpaca_requant_axis.sv
// alpaca_requant_axis: AXIS requantizer from mac_t to sample_t with convergent
// rounding, saturation, per-beat sat flag and a sticky saturation counter.
module alpaca_requant_axis
    import cx_types_pkg::*;
#(
    parameter int WIDTH      = cx_types_pkg::WIDTH,
    parameter int FRAC_WIDTH = cx_types_pkg::FRAC_WIDTH,
    parameter int TUSER_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH:0]     s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [TUSER_W-1:0]   s_axis_tuser,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [TUSER_W-1:0]   m_axis_tuser,
    output logic                 m_axis_sat,
    input  logic                 sat_clr,
    output logic [CNT_W-1:0]     sat_count
);
    localparam int MW  = 2*WIDTH + 1;
    localparam int D   = FRAC_WIDTH;
    localparam int RW  = MW + 1 - D;
    localparam int P1W = RW + 1 + TUSER_W;
    localparam int P2W = WIDTH + 2 + TUSER_W;
    localparam logic [D-1:0] HALF = {1'b1, {(D-1){1'b0}}};

    logic               en1, en2, v1, rnd_up, sat2_d;
    logic [RW-1:0]      r1_d, r1_q;
    logic               last1_q;
    logic [TUSER_W-1:0] user1_q;
    logic [RW-WIDTH:0]  up;
    logic [WIDTH-1:0]   d2_d;
    logic [CNT_W-1:0]   sat_count_d, sat_count_q;

    // Carry of (x + HALF-1 + x[D]) into the kept bits, without forming the full sum.
    always_comb begin
        rnd_up = (s_axis_tdata[D-1:0] > HALF) | ((s_axis_tdata[D-1:0] == HALF) & s_axis_tdata[D]);
        r1_d   = {s_axis_tdata[MW-1], s_axis_tdata[MW-1:D]} + {{(RW-1){1'b0}}, rnd_up};
    end

    assign s_axis_tready = en1;

    alpaca_axis_pipe_reg #(.W(P1W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (s_axis_tvalid),
        .data_i  ({r1_d, s_axis_tlast, s_axis_tuser}),
        .ready_i (en2),
        .en_o    (en1),
        .valid_o (v1),
        .data_o  ({r1_q, last1_q, user1_q})
    );

    // Out of range exactly when the bits above the sample sign are not all equal.
    always_comb begin
        up     = r1_q[RW-1:WIDTH-1];
        sat2_d = (|up) & ~(&up);
        d2_d   = sat2_d ? {r1_q[RW-1], {(WIDTH-1){~r1_q[RW-1]}}} : r1_q[WIDTH-1:0];
    end

    alpaca_axis_pipe_reg #(.W(P2W)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (v1),
        .data_i  ({sat2_d, d2_d, last1_q, user1_q}),
        .ready_i (m_axis_tready),
        .en_o    (en2),
        .valid_o (m_axis_tvalid),
        .data_o  ({m_axis_sat, m_axis_tdata, m_axis_tlast, m_axis_tuser})
    );

    always_comb begin
        sat_count_d = sat_clr ? '0
                    : (m_axis_tvalid & m_axis_tready & m_axis_sat & ~(&sat_count_q)) ? sat_count_q + CNT_W'(1)
                    : sat_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count_q <= '0;
        else
            sat_count_q <= sat_count_d;
    end

    assign sat_count = sat_count_q;
endmodule

// File: tb/tb_alpaca_requant_axis.sv
// tb_alpaca_requant_axis: directed rounding/saturation vectors, backpressure and
// random streams against conv_round_sat, counter boundaries and async reset.
module tb_alpaca_requant_axis;
    import cx_types_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        sat;
        logic        last;
        logic [7:0]  user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tuser = '0;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [7:0]  m_tuser;
    logic        m_sat;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alpaca_requant_axis dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_sat    (m_sat),
        .sat_clr       (sat_clr),
        .sat_count     (sat_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One beat with tready high: invisible after one edge, present after two.
    task automatic drive_check(input string tag, input logic [32:0] x, input logic [15:0] d, input logic s);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = x;
        s_tlast  = 1'b1;
        s_tuser  = 8'h5A;
        @(negedge clk);
        s_tvalid = 1'b0;
        chk({tag, "_lat1"}, m_tvalid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, m_tvalid, 1);
        chk({tag, "_data"}, m_tdata, d);
        chk({tag, "_sat"}, m_sat, s);
        chk({tag, "_side"}, {m_tlast, m_tuser}, 9'h15A);
    endtask

    task automatic send_burst(input int n, input logic [32:0] x);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = x;
        repeat (n) @(negedge clk);
        s_tvalid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_stream(input int n, input bit rnd);
        logic [32:0] bp_vec [10];
        beat_t q [$];
        beat_t e;
        req_res_t r;
        logic signed [63:0] t;
        logic [32:0] x;
        logic [25:0] prev;
        logic [15:0] cnt_m;
        logic stall, have;
        int sent, cyc, budget;
        bp_vec = '{33'h0_0000_4000, 33'h0_4000_0000, 33'h0_0000_C000, 33'h1_BFFF_8000, 33'h1_FFFF_4000,
                   33'h0_0001_4000, 33'h0_3FFF_FFFF, 33'h1_C000_0000, 33'h0_0000_4001, 33'h0_7FFF_0000};
        sent = 0; cyc = 0; budget = n*8 + 100;
        cnt_m = '0; stall = 1'b0; have = 1'b0; prev = '0; x = '0;
        while ((sent < n || q.size() > 0) && cyc < budget) begin
            @(posedge clk);
            #1;
            if (!have && sent < n) begin
                if (rnd) begin
                    t = {$urandom(), $urandom()};
                    t = t >>> $urandom_range(28, 48);
                    x = t[32:0];
                    if ($urandom_range(0, 3) == 0) x[14:0] = 15'h4000;
                    s_tlast = 1'($urandom_range(0, 1));
                end else begin
                    x = bp_vec[sent];
                    s_tlast = (sent == 4 || sent == 9);
                end
                s_tuser = sent[7:0];
                have = 1'b1;
            end
            s_tdata  = x;
            s_tvalid = (sent < n) && (!rnd || $urandom_range(0, 7) != 0);
            m_tready = rnd ? ($urandom_range(0, 7) != 0) : (cyc % 3 == 0);
            @(negedge clk);
            chk("s_tready", s_tready, (q.size() < 2) || m_tready);
            if (stall) chk("hold", {m_tdata, m_sat, m_tlast, m_tuser}, prev);
            if (m_tvalid && m_tready) begin
                chk("beat_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("beat", {m_tdata, m_sat, m_tlast, m_tuser}, e);
                    if (e.sat && cnt_m != 16'hFFFF) cnt_m++;
                end
            end
            if (s_tvalid && s_tready) begin
                r = conv_round_sat(mac_t'(x));
                q.push_back('{d: r.d, sat: r.sat, last: s_tlast, user: s_tuser});
                sent++;
                have = 1'b0;
            end
            stall = m_tvalid && !m_tready;
            prev  = {m_tdata, m_sat, m_tlast, m_tuser};
            cyc++;
        end
        chk("stream_timeout", cyc < budget, 1);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        chk("stream_cnt", sat_count, cnt_m);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_out", {m_tdata, m_sat, m_tlast, m_tuser}, 0);
        chk("rst_cnt", sat_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", s_tready, 1);

        drive_check("half_0p5",   33'h0_0000_4000, 16'h0000, 1'b0);
        drive_check("half_1p5",   33'h0_0000_C000, 16'h0002, 1'b0);
        drive_check("above_half", 33'h0_0000_4001, 16'h0001, 1'b0);
        drive_check("half_2p5",   33'h0_0001_4000, 16'h0002, 1'b0);
        drive_check("neg_1p5",    33'h1_FFFF_4000, 16'hFFFE, 1'b0);
        drive_check("neg_min",    33'h1_C000_0000, 16'h8000, 1'b0);
        drive_check("pos_sat",    33'h0_4000_0000, 16'h7FFF, 1'b1);
        drive_check("neg_sat",    33'h1_BFFF_8000, 16'h8000, 1'b1);
        @(negedge clk);
        chk("sat_cnt_2", sat_count, 2);

        do_reset();
        run_stream(10, 1'b0);

        do_reset();
        send_burst(65534, 33'h0_4000_0000);
        chk("cnt_fffe", sat_count, 16'hFFFE);
        send_burst(3, 33'h0_4000_0000);
        chk("cnt_stick", sat_count, 16'hFFFF);

        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 33'h0_4000_0000;
        @(negedge clk);
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("clr_beat_sat", {m_tvalid, m_sat}, 2'b11);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("clr_wins", sat_count, 0);
        send_burst(1, 33'h1_BFFF_8000);
        chk("cnt_after_clr", sat_count, 1);

        m_tready = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 33'h0_4000_0000;
        @(negedge clk);
        s_tdata  = 33'h0_0000_C000;
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("full_tvalid", m_tvalid, 1);
        chk("full_stall_tready", s_tready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_tvalid", m_tvalid, 0);
        chk("async_cnt", sat_count, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        m_tready = 1'b1;
        drive_check("post_rst", 33'h1_FFFF_4000, 16'hFFFE, 1'b0);

        do_reset();
        run_stream(10000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
